// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator: pixel-rate divider, x/y raster counters
// and registered sync/blanking outputs aligned with the counters.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       Hsync,
    output logic       Vsync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, vsync_q, video_on_q;
    logic             tick;

    // Gated by reset so a CLK_DIV=1 instance does not tick while held in reset.
    assign tick = (div_q == DIV_LAST) && !reset;

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Sync and blanking decode the next counter values so they land on the
    // same edge as x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= !((x_d >= HS_START) && (x_d < HS_END));
            vsync_q    <= !((y_d >= VS_START) && (y_d < VS_END));
            video_on_q <= (x_d < H_VIS) && (y_d < V_VIS);
        end
    end

    assign pix_tick    = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = tick && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, CLK_DIV=1, tiny raster)
// checked every clock against a scoreboard fed by a reference raster model.
module tb_vga_sync_gen;

    typedef struct {
        logic       pix_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       pt[3], vo[3], hs[3], vs[3], fs[3];
    logic [9:0] xs[3], ys[3];

    int cd[3] = '{4, 1, 2};
    int ha[3] = '{640, 640, 16};
    int hf[3] = '{16, 16, 2};
    int hw[3] = '{96, 96, 4};
    int hb[3] = '{48, 48, 3};
    int va[3] = '{480, 480, 8};
    int vf[3] = '{10, 10, 2};
    int vw[3] = '{2, 2, 2};
    int vb[3] = '{33, 33, 3};

    int mdiv[3], mx[3], my[3];
    exp_t sb[$];
    int ncmp = 0;
    int nbad = 0;
    int edge_n = 0;

    vga_sync_gen u_d0 (
        .clk(clk), .reset(reset), .pix_tick(pt[0]), .x(xs[0]), .y(ys[0]),
        .video_on(vo[0]), .Hsync(hs[0]), .Vsync(vs[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .pix_tick(pt[1]), .x(xs[1]), .y(ys[1]),
        .video_on(vo[1]), .Hsync(hs[1]), .Vsync(vs[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_d2 (
        .clk(clk), .reset(reset), .pix_tick(pt[2]), .x(xs[2]), .y(ys[2]),
        .video_on(vo[2]), .Hsync(hs[2]), .Vsync(vs[2]), .frame_start(fs[2])
    );

    task automatic cmp(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] expv);
        ncmp++;
        assert (got === expv) else begin
            nbad++;
            $error("FAIL %s[%0d] @edge %0d observed=%0d expected=%0d", tag, k, edge_n, got, expv);
        end
    endtask

    function automatic exp_t decode(input int k);
        exp_t e;
        int   ht, vt;
        ht = ha[k] + hf[k] + hw[k] + hb[k];
        vt = va[k] + vf[k] + vw[k] + vb[k];
        e.pix_tick    = !reset && (mdiv[k] == cd[k] - 1);
        e.x           = 10'(mx[k]);
        e.y           = 10'(my[k]);
        e.video_on    = (mx[k] < ha[k]) && (my[k] < va[k]);
        e.hsync       = !((mx[k] >= ha[k] + hf[k]) && (mx[k] < ha[k] + hf[k] + hw[k]));
        e.vsync       = !((my[k] >= va[k] + vf[k]) && (my[k] < va[k] + vf[k] + vw[k]));
        e.frame_start = e.pix_tick && (mx[k] == ht - 1) && (my[k] == vt - 1);
        return e;
    endfunction

    task automatic model_edge(input int k);
        int ht, vt;
        ht = ha[k] + hf[k] + hw[k] + hb[k];
        vt = va[k] + vf[k] + vw[k] + vb[k];
        if (reset) begin
            mdiv[k] = 0; mx[k] = 0; my[k] = 0;
        end else if (mdiv[k] == cd[k] - 1) begin
            mdiv[k] = 0;
            if (mx[k] == ht - 1) begin
                mx[k] = 0;
                my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
            end else begin
                mx[k] = mx[k] + 1;
            end
        end else begin
            mdiv[k] = mdiv[k] + 1;
        end
    endtask

    task automatic check_all();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            cmp("pix_tick", k, 32'(pt[k]), 32'(e.pix_tick));
            cmp("x", k, 32'(xs[k]), 32'(e.x));
            cmp("y", k, 32'(ys[k]), 32'(e.y));
            cmp("video_on", k, 32'(vo[k]), 32'(e.video_on));
            cmp("Hsync", k, 32'(hs[k]), 32'(e.hsync));
            cmp("Vsync", k, 32'(vs[k]), 32'(e.vsync));
            cmp("frame_start", k, 32'(fs[k]), 32'(e.frame_start));
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            model_edge(k);
            sb.push_back(decode(k));
        end
        #1;
        check_all();
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        step();
        step();
        cmp("rst_pix_tick_div1", 1, 32'(pt[1]), 32'd0);
        cmp("rst_video_on", 0, 32'(vo[0]), 32'd1);

        release_reset();
        run_to(2);
        cmp("tick_early", 0, 32'(pt[0]), 32'd0);
        run_to(3);
        cmp("tick_first", 0, 32'(pt[0]), 32'd1);
        cmp("x_before_tick", 0, 32'(xs[0]), 32'd0);
        cmp("tick_div1", 1, 32'(pt[1]), 32'd1);
        run_to(4);
        cmp("x_first", 0, 32'(xs[0]), 32'd1);

        // Tiny raster: frame_start on the last tick of the frame, then (0,0).
        run_to(748);
        cmp("fs_before", 2, 32'(fs[2]), 32'd0);
        run_to(749);
        cmp("fs_pulse", 2, 32'(fs[2]), 32'd1);
        run_to(750);
        cmp("x_wrap", 2, 32'(xs[2]), 32'd0);
        cmp("y_wrap", 2, 32'(ys[2]), 32'd0);

        run_to(2623);
        cmp("x_pre_sync", 0, 32'(xs[0]), 32'd655);
        cmp("hsync_pre", 0, 32'(hs[0]), 32'd1);
        run_to(2624);
        cmp("hsync_fall", 0, 32'(hs[0]), 32'd0);
        run_to(2800);
        cmp("x_mid", 0, 32'(xs[0]), 32'd700);
        cmp("hsync_mid", 0, 32'(hs[0]), 32'd0);
        cmp("video_off", 0, 32'(vo[0]), 32'd0);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            model_edge(k);
            sb.push_back(decode(k));
        end
        check_all();
        cmp("async_x", 0, 32'(xs[0]), 32'd0);
        cmp("async_hsync", 0, 32'(hs[0]), 32'd1);
        step();
        step();

        release_reset();
        run_to(3);
        cmp("re_tick_first", 0, 32'(pt[0]), 32'd1);
        run_to(3008);
        cmp("hsync_rise", 0, 32'(hs[0]), 32'd1);
        cmp("x_752", 0, 32'(xs[0]), 32'd752);
        run_to(3200);
        cmp("line_wrap_x", 0, 32'(xs[0]), 32'd0);
        cmp("line_wrap_y", 0, 32'(ys[0]), 32'd1);
        run_to(3300);
        cmp("div1_x", 1, 32'(xs[1]), 32'd100);
        cmp("div1_y", 1, 32'(ys[1]), 32'd4);
        run_to(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
